coin_serializer: RTL
====================

# coin_serializer

Upstream front end of `vendingMachine`. It accepts coin-detect events from the coin acceptor through a valid/ready handshake and buffers them in a small FIFO. It then emits each coin as a 12-bit serial frame on `ser_out`, with a one-cycle low `frame_en` boundary marker, which is the exact stream `vendingMachine` consumes on `serialIn`/`enable`. Coins arriving while the FIFO is full are rejected back to the customer.

## Interface
- `FIFO_DEPTH`, 4: coin buffer entries; power of two, ≥2.
- `FRAME_W`, 12: bits per serial frame.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low: `reset==0` at a rising edge clears all state.
- `coin_valid`  in  1  acceptor presents a coin this cycle.
- `coin_type`  in  2  00 penny, 01 nickel, 10 dime, 11 quarter.
- `coin_ready`  out  1  FIFO not full; a coin is accepted when `coin_valid && coin_ready` at an edge.
- `ser_out`  out  1  serial frame data, LSB first; drives `vendingMachine.serialIn`.
- `frame_en`  out  1  active-low frame boundary strobe; drives `vendingMachine.enable`.
- `busy`  out  1  frame or commit in progress, or FIFO non-empty.
- `coin_return`  out  1  one-cycle pulse: the coin was refused.

## Operation
- Frame codes, as `{bit11..bit0}`:
  - penny `1011_1100_0000`
  - nickel `1101_0000_0000`
  - dime `1011_0000_0000`
  - quarter `1110_1111_0000`
- FSM states:
  - IDLE: `ser_out=0`, `frame_en=1`. If the FIFO is non-empty, pop, load the shift register with the code, clear `bit_idx`, and go to SEND.
  - SEND: each cycle presents `code[bit_idx]`; `frame_en=0` only when `bit_idx==0`. After `bit_idx==11`:
    - FIFO non-empty: pop and reload, staying in SEND with no gap cycle. The next frame's bit 0 and low `frame_en` follow immediately.
    - FIFO empty: go to COMMIT.
  - COMMIT: one cycle with `ser_out=0` and `frame_en=0`, then IDLE. This commits the last frame of a burst downstream.
- FIFO: `coin_ready = !full`, evaluated from state at the start of the cycle.
  - Push and pop in the same cycle are legal when the FIFO is neither empty nor full.
  - When full, a same-cycle pop does not make room for that cycle's push.
- Reject: if `coin_valid && !coin_ready`, `coin_return=1` in the next cycle. The coin is not stored.
- `busy = (state!=IDLE) || !empty`.

## Timing
- Reset values: `ser_out=0`, `frame_en=1`, `coin_ready=1`, `busy=0`, `coin_return=0`. On reset the FIFO is empty, the FSM is in IDLE, and `bit_idx=0`.
- All outputs are registered except `coin_ready` and `busy`, which are decoded from registered state.
- Latency, with FIFO empty and FSM in IDLE: a coin accepted at edge E0 puts bit 0 (with `frame_en=0`) on the outputs after edge E2.
- One frame occupies exactly 12 cycles. A burst of N coins occupies 12N+1 cycles, including COMMIT.
- Reset mid-frame or mid-COMMIT aborts immediately and flushes the FIFO. No COMMIT strobe is emitted; outputs take reset values after that edge.
- `bit_idx` wraps 11→0 only on a reload. The counter never exceeds 11.

## Structure
- Package `coin_pkg` holds:
  - the `coin_t` enum (PENNY, NICKEL, DIME, QUARTER)
  - `FRAME_W`
  - the four 12-bit code constants
  - the FSM state enum
- Sub-module `coin_fifo`: parameterised synchronous FIFO with `push`, `pop`, `din[1:0]`, `dout`, `full`, `empty`, and active-low sync `reset`. The top-level block holds the FSM, shift register, bit counter, and reject pulse.

## Test plan
- Single penny after reset → after edge E2, `ser_out` sequence 0,0,0,0,0,0,1,1,1,1,0,1 with `frame_en` low only on the first cycle, then one COMMIT cycle (0/0), then IDLE (0/1).
- Penny, nickel, dime, quarter on four consecutive cycles → 48 contiguous bits matching the four codes, `frame_en` low at cycles 0, 12, 24, 36 and 48 (COMMIT), `coin_return` never set.
- Six coins on consecutive cycles, `FIFO_DEPTH=4` → `coin_ready` drops once full. Each refused coin produces `coin_return=1` the next cycle, and exactly the accepted coins are serialised in order.
- Quarter accepted, `reset=0` at frame bit 5 → next cycle `ser_out=0`, `frame_en=1`, `busy=0`, and no COMMIT strobe. A dime sent after release serialises cleanly.
- Push while SEND pops at `bit_idx==11` with 1 entry queued → both coins framed back-to-back with no idle cycle and no data loss.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared types and constants for the coin serializer.
// Coin encodings, frame codes and FSM states.
package coin_pkg;

    typedef enum logic [1:0] {
        PENNY   = 2'b00,
        NICKEL  = 2'b01,
        DIME    = 2'b10,
        QUARTER = 2'b11
    } coin_t;

    localparam int FRAME_W = 12;

    localparam logic [FRAME_W-1:0] CODE_PENNY   = 12'b1011_1100_0000;
    localparam logic [FRAME_W-1:0] CODE_NICKEL  = 12'b1101_0000_0000;
    localparam logic [FRAME_W-1:0] CODE_DIME    = 12'b1011_0000_0000;
    localparam logic [FRAME_W-1:0] CODE_QUARTER = 12'b1110_1111_0000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SEND   = 2'b01,
        S_COMMIT = 2'b10
    } state_t;

    function automatic logic [FRAME_W-1:0] coin_code(input coin_t c);
        logic [FRAME_W-1:0] code;
        unique case (c)
            PENNY:   code = CODE_PENNY;
            NICKEL:  code = CODE_NICKEL;
            DIME:    code = CODE_DIME;
            QUARTER: code = CODE_QUARTER;
            default: code = CODE_PENNY;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/coin_fifo.sv
// Small synchronous FIFO holding accepted coin types.
// Push is ignored when full even if a pop happens in the same cycle.
module coin_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign dout   = r_mem[r_rptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/coin_serializer.sv
// Buffers coin events and emits each as a serial frame,
// LSB first, with a low frame_en marker on bit 0 and COMMIT.
module coin_serializer
    import coin_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_W    = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    output logic       coin_ready,
    output logic       ser_out,
    output logic       frame_en,
    output logic       busy,
    output logic       coin_return
);

    localparam int BW = $clog2(FRAME_W);
    localparam logic [BW-1:0] LAST = BW'(FRAME_W - 1);

    state_t r_state;
    state_t w_next_state;

    logic [FRAME_W-1:0] r_shift;
    logic [BW-1:0]      r_bit_idx;

    logic r_ser_out;
    logic r_frame_en;
    logic r_coin_return;

    logic       w_full;
    logic       w_empty;
    logic [1:0] w_dout;
    logic       w_push;
    logic       w_pop;
    logic       w_load;
    logic       w_ser;
    logic       w_fe;

    assign w_push = coin_valid && !w_full;

    coin_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (coin_type),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign coin_ready  = !w_full;
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign ser_out     = r_ser_out;
    assign frame_en    = r_frame_en;
    assign coin_return = r_coin_return;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, FIFO pop and the pre-register output values.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_ser        = 1'b0;
        w_fe         = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_load       = 1'b1;
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                w_ser = r_shift[0];
                w_fe  = (r_bit_idx != '0);
                if (r_bit_idx == LAST) begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                    end else begin
                        w_next_state = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                w_fe         = 1'b0;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Shift register and bit counter; counter holds at LAST until reload.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else if (w_load) begin
            r_shift   <= coin_code(coin_t'(w_dout));
            r_bit_idx <= '0;
        end else if (r_state == S_SEND && r_bit_idx != LAST) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 1'b1;
        end
    end

    // Registered outputs and the one-cycle reject pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ser_out     <= 1'b0;
            r_frame_en    <= 1'b1;
            r_coin_return <= 1'b0;
        end else begin
            r_ser_out     <= w_ser;
            r_frame_en    <= w_fe;
            r_coin_return <= coin_valid && w_full;
        end
    end

endmodule
